// File: rtl/micro_seq.sv
// micro_seq: microprogram sequencer. Computes the next control-store address
// from the sequencing field of the current control word, dispatches on the
// opcode, counts retired instructions and flags undecodable opcodes.
module micro_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_wait,
  input  logic [5:0]  op,
  input  logic [1:0]  seq,
  output logic [3:0]  mpc,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned MPC_W = 4;
  localparam int unsigned RET_W = 16;

  // Sequencing field encodings of the control word
  localparam logic [1:0] SEQ_FETCH = 2'b00;
  localparam logic [1:0] SEQ_DISP1 = 2'b01;
  localparam logic [1:0] SEQ_DISP2 = 2'b10;
  localparam logic [1:0] SEQ_NEXT  = 2'b11;

  // Opcodes understood by the dispatch tables
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_RTYP = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  logic [MPC_W-1:0] r_mpc;
  logic             r_instr_done;
  logic             r_illegal;
  logic [RET_W-1:0] r_retired;

  logic             w_d1_valid;
  logic [MPC_W-1:0] w_d1_tgt;
  logic             w_d2_valid;
  logic [MPC_W-1:0] w_d2_tgt;
  logic             w_active;

  // Dispatch-1 table: first microinstruction after decode
  always_comb begin
    w_d1_valid = 1'b1;
    w_d1_tgt   = MPC_W'(0);
    case (op)
      OP_LW, OP_SW: w_d1_tgt = MPC_W'(2);
      OP_RTYP:      w_d1_tgt = MPC_W'(6);
      OP_BEQ:       w_d1_tgt = MPC_W'(8);
      OP_J:         w_d1_tgt = MPC_W'(9);
      default:      w_d1_valid = 1'b0;
    endcase
  end

  // Dispatch-2 table: memory access split between loads and stores
  always_comb begin
    w_d2_valid = 1'b1;
    w_d2_tgt   = MPC_W'(0);
    case (op)
      OP_LW:   w_d2_tgt = MPC_W'(3);
      OP_SW:   w_d2_tgt = MPC_W'(5);
      default: w_d2_valid = 1'b0;
    endcase
  end

  // A cycle advances only when memory is ready and we are not idling at fetch
  assign w_active = !mem_wait && ((r_mpc != MPC_W'(0)) || run);

  // Sequencer state: next address, retire pulse/counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mpc        <= MPC_W'(0);
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= RET_W'(0);
    end else begin
      r_instr_done <= 1'b0;
      if (w_active) begin
        case (seq)
          SEQ_NEXT: r_mpc <= r_mpc + MPC_W'(1);
          SEQ_DISP1: begin
            if (w_d1_valid) begin
              r_mpc <= w_d1_tgt;
            end else begin
              r_mpc     <= MPC_W'(0);
              r_illegal <= 1'b1;
            end
          end
          SEQ_DISP2: begin
            if (w_d2_valid) begin
              r_mpc <= w_d2_tgt;
            end else begin
              r_mpc     <= MPC_W'(0);
              r_illegal <= 1'b1;
            end
          end
          default: begin
            // Return to fetch; only a return from inside an instruction retires it
            r_mpc <= MPC_W'(0);
            if (r_mpc != MPC_W'(0)) begin
              r_instr_done <= 1'b1;
              r_retired    <= r_retired + RET_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign mpc        = r_mpc;
  assign instr_done = r_instr_done;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_micro_seq.sv
// Bench for micro_seq: directed microprogram scenarios with literal
// expectations, plus randomized stimulus checked every cycle against a
// behavioural model of the sequencing rules.
module tb_micro_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_wait;
  logic [5:0]  op;
  logic [1:0]  seq;
  logic [3:0]  mpc;
  logic        instr_done;
  logic        illegal;
  logic [15:0] retired;

  logic        use_rom;
  logic [1:0]  seq_rand;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  int m_mpc  = 0;
  int m_ret  = 0;
  bit m_done = 1'b0;
  bit m_ill  = 1'b0;
  int d1[int];
  int d2[int];

  micro_seq dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_wait   (mem_wait),
    .op         (op),
    .seq        (seq),
    .mpc        (mpc),
    .instr_done (instr_done),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Control store sequencing fields: fetch, decode, lw/sw, R-type, beq, j
  function automatic logic [1:0] ucode(input logic [3:0] a);
    case (a)
      4'd0:    ucode = 2'b11;
      4'd1:    ucode = 2'b01;
      4'd2:    ucode = 2'b10;
      4'd3:    ucode = 2'b11;
      4'd6:    ucode = 2'b11;
      default: ucode = 2'b00;
    endcase
  endfunction

  assign seq = use_rom ? ucode(mpc) : seq_rand;

  // Reference model: one transition per non-stalled, non-idle clock
  always @(posedge clk) begin
    int s;
    s = int'(seq);
    if (rst) begin
      m_mpc <= 0; m_ret <= 0; m_done <= 1'b0; m_ill <= 1'b0;
    end else if (mem_wait || (m_mpc == 0 && !run)) begin
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (s == 3) begin
        m_mpc <= (m_mpc + 1) % 16;
      end else if (s == 0) begin
        m_mpc <= 0;
        if (m_mpc != 0) begin
          m_done <= 1'b1;
          m_ret  <= (m_ret + 1) % 65536;
        end
      end else if (s == 1 && d1.exists(int'(op))) begin
        m_mpc <= d1[int'(op)];
      end else if (s == 2 && d2.exists(int'(op))) begin
        m_mpc <= d2[int'(op)];
      end else begin
        m_mpc <= 0;
        m_ill <= 1'b1;
      end
    end
  end

  // Compare process: DUT outputs against the model on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks += 4;
      if (int'(mpc) != m_mpc) begin
        n_fail++; $display("FAIL model_mpc t=%0t got %0d expected %0d", $time, mpc, m_mpc);
      end
      if (int'(retired) != m_ret) begin
        n_fail++; $display("FAIL model_retired t=%0t got %0d expected %0d", $time, retired, m_ret);
      end
      if (instr_done !== m_done) begin
        n_fail++; $display("FAIL model_instr_done t=%0t got %0b expected %0b", $time, instr_done, m_done);
      end
      if (illegal !== m_ill) begin
        n_fail++; $display("FAIL model_illegal t=%0t got %0b expected %0b", $time, illegal, m_ill);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input int exp);
    n_checks++;
    if ($isunknown(act) || int'(act) != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_mpc(input string name, input int exp);
    step();
    chk(name, 16'(mpc), exp);
  endtask

  initial begin
    int ops[5];
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02};
    d1[6'h23] = 2; d1[6'h2B] = 2; d1[6'h00] = 6; d1[6'h04] = 8; d1[6'h02] = 9;
    d2[6'h23] = 3; d2[6'h2B] = 5;

    rst = 1'b1; run = 1'b1; mem_wait = 1'b0; op = 6'h3F;
    use_rom = 1'b1; seq_rand = 2'b00;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mpc", 16'(mpc), 0);
    chk("rst_done", 16'(instr_done), 0);
    chk("rst_illegal", 16'(illegal), 0);
    chk("rst_retired", retired, 0);

    // lw: 0,1,2,3,4,0 with one retire
    rst = 1'b0; op = 6'h23;
    step_mpc("lw_mpc1", 1);
    step_mpc("lw_mpc2", 2);
    step_mpc("lw_mpc3", 3);
    step_mpc("lw_mpc4", 4);
    chk("lw_no_early_done", 16'(instr_done), 0);
    run = 1'b0;
    step_mpc("lw_mpc0", 0);
    chk("lw_done", 16'(instr_done), 1);
    chk("lw_retired", retired, 1);
    step_mpc("lw_idle", 0);
    chk("lw_done_one_cycle", 16'(instr_done), 0);

    // sw with a 3-cycle stall at mpc=5
    run = 1'b1; op = 6'h2B;
    step_mpc("sw_mpc1", 1);
    step_mpc("sw_mpc2", 2);
    step_mpc("sw_mpc5", 5);
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_mpc("sw_stall_mpc", 5);
      chk("sw_stall_done", 16'(instr_done), 0);
    end
    mem_wait = 1'b0; run = 1'b0;
    step_mpc("sw_mpc0", 0);
    chk("sw_done", 16'(instr_done), 1);
    chk("sw_retired", retired, 2);

    // R-type then beq with no gap cycles
    run = 1'b1; op = 6'h00;
    step_mpc("rb_mpc1", 1);
    step_mpc("rb_mpc6", 6);
    step_mpc("rb_mpc7", 7);
    op = 6'h04;
    step_mpc("rb_mpc0a", 0);
    chk("rb_done_a", 16'(instr_done), 1);
    step_mpc("rb_mpc1b", 1);
    step_mpc("rb_mpc8", 8);
    run = 1'b0;
    step_mpc("rb_mpc0b", 0);
    chk("rb_retired", retired, 4);

    // mem_wait wins over run at fetch
    run = 1'b1; mem_wait = 1'b1;
    step_mpc("wait_prio_mpc", 0);
    step_mpc("wait_prio_mpc2", 0);
    mem_wait = 1'b0;

    // Illegal opcode at decode
    op = 6'h3F;
    step_mpc("ill_mpc1", 1);
    run = 1'b0;
    step_mpc("ill_mpc0", 0);
    chk("ill_flag", 16'(illegal), 1);
    chk("ill_done", 16'(instr_done), 0);
    chk("ill_retired", retired, 4);
    step();
    chk("ill_sticky", 16'(illegal), 1);

    // Reset mid-instruction at mpc=3
    run = 1'b1; op = 6'h23;
    step_mpc("rmid_mpc1", 1);
    step_mpc("rmid_mpc2", 2);
    step_mpc("rmid_mpc3", 3);
    rst = 1'b1;
    step_mpc("rmid_mpc", 0);
    chk("rmid_retired", retired, 0);
    chk("rmid_illegal", 16'(illegal), 0);
    chk("rmid_done", 16'(instr_done), 0);
    rst = 1'b0;

    // 65535 j instructions back to back, then one more to wrap the counter
    run = 1'b1; op = 6'h02;
    repeat (3 * 65535 - 1) @(posedge clk);
    @(negedge clk);
    chk("j_last_mpc9", 16'(mpc), 9);
    run = 1'b0;
    step_mpc("j_mpc0", 0);
    chk("j_retired_ffff", retired, 65535);
    run = 1'b1;
    step_mpc("wrap_mpc1", 1);
    step_mpc("wrap_mpc9", 9);
    run = 1'b0;
    step_mpc("wrap_mpc0", 0);
    chk("wrap_retired", retired, 0);
    chk("wrap_done", 16'(instr_done), 1);
    for (int i = 0; i < 10; i++) begin
      step_mpc("idle_mpc", 0);
      chk("idle_done", 16'(instr_done), 0);
    end

    // Randomized phase: free-running seq first (reaches 4'hF wrap), then control store
    for (int i = 0; i < 3000; i++) begin
      int k;
      use_rom  = (i >= 1500);
      rst      = ($urandom_range(0, 63) == 0);
      mem_wait = ($urandom_range(0, 3) == 0);
      run      = ($urandom_range(0, 3) != 0);
      seq_rand = 2'($urandom_range(0, 3));
      if (i < 1500 && $urandom_range(0, 1) == 0) seq_rand = 2'b11;
      k = $urandom_range(0, 15);
      op = (k < 14) ? 6'(ops[k % 5]) : 6'($urandom_range(0, 63));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
